// File: rtl/reg_fifo_pkg.sv
// Shared defaults and helpers for the register-stage FIFO.
package reg_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int AW_DEF     = 3;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// Producer/consumer strobe bus plus status flags of the register-stage FIFO.
interface reg_fifo_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic [N-1:0] d;
    logic         wr;
    logic         rd;
    logic [N-1:0] q;
    logic         full;
    logic         empty;
    logic [AW:0]  count;
    logic         overflow;
    logic         underflow;

    modport master (
        output d, wr, rd,
        input  q, full, empty, count, overflow, underflow
    );

    modport slave (
        input  d, wr, rd,
        output q, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/reg_fifo_mem.sv
// DEPTH x N storage: one synchronous write port, one registered read port.
module reg_fifo_mem #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);
    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read sees the pre-write contents, so a pop and push on the same slot while full is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/reg_fifo.sv
// FIFO behind the n-bit register stage: wrap-bit pointers, flags and sticky errors.
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter int N     = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input logic       clk,
    input logic       rst,
    reg_fifo_if.slave bus
);
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push_ok;
    logic        pop_ok;
    logic        overflow;
    logic        underflow;

    if (DEPTH != (1 << AW) || log2_ceil(DEPTH) != AW || DEPTH < 2) begin : g_bad_depth
        $error("reg_fifo: DEPTH (%0d) must be a power of two >= 2 equal to 2**AW (AW=%0d)", DEPTH, AW);
    end

    // Flags come only from registered pointers, never from the strobes.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign pop_ok  = bus.rd & ~empty;
    assign push_ok = bus.wr & (~full | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)                    wr_ptr    <= wr_ptr + 1'b1;
            if (pop_ok)                     rd_ptr    <= rd_ptr + 1'b1;
            if (bus.wr && full && !pop_ok)  overflow  <= 1'b1;
            if (bus.rd && empty)            underflow <= 1'b1;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;

    reg_fifo_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.d),
        .re    (pop_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.q)
    );
endmodule

// File: tb/tb_reg_fifo.sv
// Bench for reg_fifo: fixed vector table, corner-case sequences, random run against a queue model.
module tb_reg_fifo;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_fifo_if #(.N(N), .AW(AW)) bus ();

    reg_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] d;
        logic [7:0] q;
        int         count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs [9];

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_q;
    logic       m_ovf;
    logic       m_unf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q, input int count,
                           input logic full, input logic empty, input logic ovf, input logic unf);
        chk({tag, " q"},         int'(bus.q),         int'(q));
        chk({tag, " count"},     int'(bus.count),     count);
        chk({tag, " full"},      int'(bus.full),      int'(full));
        chk({tag, " empty"},     int'(bus.empty),     int'(empty));
        chk({tag, " overflow"},  int'(bus.overflow),  int'(ovf));
        chk({tag, " underflow"}, int'(bus.underflow), int'(unf));
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] dv);
        @(negedge clk);
        bus.wr = w;
        bus.rd = r;
        bus.d  = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        mq.delete();
        m_q = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Applies one cycle to the model: pop takes effect before push, so a full FIFO accepts both.
    task automatic model_step(input logic w, input logic r, input logic [7:0] dv);
        logic pop_ok, push_ok;
        pop_ok  = r && (mq.size() > 0);
        push_ok = w && (mq.size() < DEPTH || pop_ok);
        if (r && mq.size() == 0) m_unf = 1'b1;
        if (w && !push_ok)       m_ovf = 1'b1;
        if (pop_ok)  m_q = mq.pop_front();
        if (push_ok) mq.push_back(dv);
    endtask

    initial begin
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.d  = 8'h00;
        m_q = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        //            wr rd d      q      cnt full empty ovf unf
        vecs[0] = '{1'b1, 1'b0, 8'h35, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h35, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h35, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h35, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h11, 8'h35, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h22, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h22, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 8'h99, 8'h22, 0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Power-on reset
        #10;
        rst = 1'b0;
        #1;
        chk_all("reset", 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].count, vecs[i].full,
                    vecs[i].empty, vecs[i].ovf, vecs[i].unf);
        end

        // Fill, full simultaneous push/pop, overflow, drain
        do_reset();
        #1;
        chk_all("reset2", 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        chk_all("filled", 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h77);
        chk_all("full_rdwr", 8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hFF);
        chk_all("overflow", 8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d q", i), int'(bus.q), (i == 9) ? 'h77 : i);
            chk($sformatf("drain%0d count", i), int'(bus.count), 9 - i);
        end
        chk_all("drained", 8'h77, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h00);
        chk_all("underflow", 8'h77, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Alternating push/pop carries the pointers across the wrap twice
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i));
            step(1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap%0d q", i), int'(bus.q), 'h40 + i);
        end
        chk_all("wrap_end", 8'h53, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges with data queued
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hC5);
        chk_all("pre_rst", 8'hC0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        chk_all("post_rst_pop", 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Random traffic: push-heavy phase then pop-heavy phase, against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            logic [7:0] dv;
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            dv = 8'($urandom);
            model_step(w, r, dv);
            step(w, r, dv);
            chk_all($sformatf("rnd%0d", i), m_q, mq.size(), mq.size() == DEPTH,
                    mq.size() == 0, m_ovf, m_unf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
